// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and constants for the vending transaction
//               controller: FSM states, coin and product codes, coin values.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    VEND    = 2'b01,
    PAYOUT  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_t;

  typedef enum logic [1:0] {
    PROD_NONE = 2'b00,
    PROD_A    = 2'b01,
    PROD_B    = 2'b10,
    PROD_C    = 2'b11
  } prod_t;

  localparam logic [7:0] C_VAL_NICKEL  = 8'd5;
  localparam logic [7:0] C_VAL_DIME    = 8'd10;
  localparam logic [7:0] C_VAL_QUARTER = 8'd25;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_change_sel.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_sel
// Description : Greedy change picker. Returns the largest coin whose value
//               does not exceed the given credit, plus that coin's value.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_sel
  import vend_pkg::*;
(
  input  logic [7:0] i_credit,
  output coin_t      o_coin,
  output logic [7:0] o_value
);

  // Largest-coin-first selection; zero credit yields no coin
  always_comb begin
    o_coin  = COIN_NONE;
    o_value = 8'd0;
    if (i_credit >= C_VAL_QUARTER) begin
      o_coin  = COIN_QUARTER;
      o_value = C_VAL_QUARTER;
    end else if (i_credit >= C_VAL_DIME) begin
      o_coin  = COIN_DIME;
      o_value = C_VAL_DIME;
    end else if (i_credit >= C_VAL_NICKEL) begin
      o_coin  = COIN_NICKEL;
      o_value = C_VAL_NICKEL;
    end
  end

endmodule : vend_change_sel
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller
// Description : Vending transaction controller. Accumulates coin credit,
//               accepts product selections, drives the release handshake and
//               pays change / refunds one coin at a time, largest first.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_A    = 20,
  parameter int unsigned PRICE_B    = 35,
  parameter int unsigned PRICE_C    = 50,
  parameter int unsigned MAX_CREDIT = 95
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       nickle_i,
  input  logic       dime_i,
  input  logic       quarter_i,
  input  logic       sel_valid_i,
  input  logic [1:0] sel_i,
  input  logic       cancel_i,
  input  logic       vend_ack_i,
  input  logic       pay_ready_i,
  output logic       vend_o,
  output logic [1:0] vend_sel_o,
  output logic       pay_valid_o,
  output logic [1:0] pay_coin_o,
  output logic [7:0] credit_o,
  output logic       busy_o,
  output logic       coin_reject_o,
  output logic       sel_err_o
);

  localparam logic [7:0] C_PRICE_A    = 8'(PRICE_A);
  localparam logic [7:0] C_PRICE_B    = 8'(PRICE_B);
  localparam logic [7:0] C_PRICE_C    = 8'(PRICE_C);
  localparam logic [8:0] C_MAX_CREDIT = 9'(MAX_CREDIT);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_credit, w_credit_nxt;
  logic       r_vend, w_vend_nxt;
  logic [1:0] r_vend_sel, w_vend_sel_nxt;
  logic       r_pay_valid, w_pay_valid_nxt;
  coin_t      r_pay_coin, w_pay_coin_nxt;
  logic [7:0] r_pay_value, w_pay_value_nxt;
  logic       r_busy;
  logic       r_coin_reject, w_coin_reject_nxt;
  logic       r_sel_err, w_sel_err_nxt;

  logic       w_coin_any;
  logic       w_coin_extra;
  logic [7:0] w_coin_val;
  logic [8:0] w_coin_sum;
  logic [7:0] w_price;
  coin_t      w_next_coin;
  logic [7:0] w_next_value;

  // Coin decode: nickel wins over dime wins over quarter; extras get bounced
  always_comb begin
    w_coin_any   = nickle_i | dime_i | quarter_i;
    w_coin_extra = (nickle_i & (dime_i | quarter_i)) | (dime_i & quarter_i);
    if (nickle_i)       w_coin_val = C_VAL_NICKEL;
    else if (dime_i)    w_coin_val = C_VAL_DIME;
    else if (quarter_i) w_coin_val = C_VAL_QUARTER;
    else                w_coin_val = 8'd0;
    w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
  end

  // Price lookup for the requested product
  always_comb begin
    case (sel_i)
      PROD_A:  w_price = C_PRICE_A;
      PROD_B:  w_price = C_PRICE_B;
      PROD_C:  w_price = C_PRICE_C;
      default: w_price = 8'd0;
    endcase
  end

  // Next-state, credit and handshake control
  always_comb begin
    logic w_coin_ok;
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_vend_nxt        = r_vend;
    w_vend_sel_nxt    = r_vend_sel;
    w_sel_err_nxt     = 1'b0;
    w_coin_reject_nxt = w_coin_extra;
    w_coin_ok         = 1'b0;

    case (r_state)
      COLLECT: begin
        if (cancel_i && (r_credit != 8'd0)) begin
          w_state_nxt = PAYOUT;
        end else if (sel_valid_i && (sel_i != PROD_NONE)) begin
          if (w_price <= r_credit) begin
            w_credit_nxt   = r_credit - w_price;
            w_state_nxt    = VEND;
            w_vend_nxt     = 1'b1;
            w_vend_sel_nxt = sel_i;
          end else begin
            // Refused selection leaves credit alone, so a coin may still land
            w_sel_err_nxt = 1'b1;
            w_coin_ok     = 1'b1;
          end
        end else begin
          w_coin_ok = 1'b1;
        end

        if (w_coin_any) begin
          if (w_coin_ok && (w_coin_sum <= C_MAX_CREDIT)) begin
            w_credit_nxt = w_coin_sum[7:0];
          end else begin
            w_coin_reject_nxt = 1'b1;
          end
        end
      end

      VEND: begin
        if (w_coin_any) w_coin_reject_nxt = 1'b1;
        if (vend_ack_i) begin
          w_vend_nxt     = 1'b0;
          w_vend_sel_nxt = 2'b00;
          w_state_nxt    = (r_credit != 8'd0) ? PAYOUT : COLLECT;
        end
      end

      PAYOUT: begin
        if (w_coin_any) w_coin_reject_nxt = 1'b1;
        if (r_pay_valid && pay_ready_i) begin
          w_credit_nxt = r_credit - r_pay_value;
          if (r_credit == r_pay_value) w_state_nxt = COLLECT;
        end
      end

      default: begin
        w_state_nxt    = COLLECT;
        w_vend_nxt     = 1'b0;
        w_vend_sel_nxt = 2'b00;
      end
    endcase
  end

  // Coin presented next cycle is always the greedy pick for next cycle's
  // credit, which keeps it stable while the payout unit stalls
  vend_change_sel u_change_sel (
    .i_credit (w_credit_nxt),
    .o_coin   (w_next_coin),
    .o_value  (w_next_value)
  );

  // Payout request follows the PAYOUT state
  always_comb begin
    w_pay_valid_nxt = (w_state_nxt == PAYOUT);
    w_pay_coin_nxt  = w_pay_valid_nxt ? w_next_coin  : COIN_NONE;
    w_pay_value_nxt = w_pay_valid_nxt ? w_next_value : 8'd0;
  end

  // Register state and all outputs; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= COLLECT;
      r_credit      <= 8'd0;
      r_vend        <= 1'b0;
      r_vend_sel    <= 2'b00;
      r_pay_valid   <= 1'b0;
      r_pay_coin    <= COIN_NONE;
      r_pay_value   <= 8'd0;
      r_busy        <= 1'b0;
      r_coin_reject <= 1'b0;
      r_sel_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_vend        <= w_vend_nxt;
      r_vend_sel    <= w_vend_sel_nxt;
      r_pay_valid   <= w_pay_valid_nxt;
      r_pay_coin    <= w_pay_coin_nxt;
      r_pay_value   <= w_pay_value_nxt;
      r_busy        <= (w_state_nxt != COLLECT);
      r_coin_reject <= w_coin_reject_nxt;
      r_sel_err     <= w_sel_err_nxt;
    end
  end

  assign vend_o        = r_vend;
  assign vend_sel_o    = r_vend_sel;
  assign pay_valid_o   = r_pay_valid;
  assign pay_coin_o    = r_pay_coin;
  assign credit_o      = r_credit;
  assign busy_o        = r_busy;
  assign coin_reject_o = r_coin_reject;
  assign sel_err_o     = r_sel_err;

endmodule : vend_controller
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_controller
// Description : Self-checking bench for vend_controller. Directed scenarios
//               followed by random traffic, compared every cycle against a
//               transaction-level model of the vending rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       nickle_i, dime_i, quarter_i;
  logic       sel_valid_i;
  logic [1:0] sel_i;
  logic       cancel_i, vend_ack_i, pay_ready_i;
  logic       vend_o;
  logic [1:0] vend_sel_o;
  logic       pay_valid_o;
  logic [1:0] pay_coin_o;
  logic [7:0] credit_o;
  logic       busy_o, coin_reject_o, sel_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: credit in cents plus "what is the machine doing" flags
  int         m_credit;
  bit         m_vending, m_paying;
  bit [1:0]   m_vend_sel;
  bit         m_rej, m_serr;

  vend_controller dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .nickle_i      (nickle_i),
    .dime_i        (dime_i),
    .quarter_i     (quarter_i),
    .sel_valid_i   (sel_valid_i),
    .sel_i         (sel_i),
    .cancel_i      (cancel_i),
    .vend_ack_i    (vend_ack_i),
    .pay_ready_i   (pay_ready_i),
    .vend_o        (vend_o),
    .vend_sel_o    (vend_sel_o),
    .pay_valid_o   (pay_valid_o),
    .pay_coin_o    (pay_coin_o),
    .credit_o      (credit_o),
    .busy_o        (busy_o),
    .coin_reject_o (coin_reject_o),
    .sel_err_o     (sel_err_o)
  );

  always #5 clk = ~clk;

  function automatic int greedy(input int c);
    if (c >= 25)     return 25;
    else if (c >= 10) return 10;
    else if (c >= 5)  return 5;
    return 0;
  endfunction

  function automatic bit [1:0] coin_code(input int v);
    case (v)
      25:      return 2'b11;
      10:      return 2'b10;
      5:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int price(input bit [1:0] s);
    case (s)
      2'b01:   return 20;
      2'b10:   return 35;
      2'b11:   return 50;
      default: return 0;
    endcase
  endfunction

  // Apply the vending rules to the inputs sampled at this clock edge
  task automatic model_step();
    int  ncoins, cval;
    bit  taken;
    if (!rst_ni) begin
      m_credit = 0; m_vending = 0; m_paying = 0;
      m_vend_sel = 0; m_rej = 0; m_serr = 0;
      return;
    end
    m_serr = 0;
    ncoins = int'(nickle_i) + int'(dime_i) + int'(quarter_i);
    cval   = nickle_i ? 5 : (dime_i ? 10 : (quarter_i ? 25 : 0));
    m_rej  = (ncoins > 1);
    if (m_vending) begin
      if (cval != 0) m_rej = 1;
      if (vend_ack_i) begin
        m_vending  = 0;
        m_vend_sel = 0;
        m_paying   = (m_credit > 0);
      end
    end else if (m_paying) begin
      if (cval != 0) m_rej = 1;
      if (pay_ready_i) begin
        m_credit = m_credit - greedy(m_credit);
        if (m_credit == 0) m_paying = 0;
      end
    end else begin
      taken = 0;
      if (cancel_i && m_credit > 0) begin
        m_paying = 1;
        taken    = 1;
      end else if (sel_valid_i && sel_i != 2'b00) begin
        if (price(sel_i) <= m_credit) begin
          m_credit   = m_credit - price(sel_i);
          m_vending  = 1;
          m_vend_sel = sel_i;
          taken      = 1;
        end else begin
          m_serr = 1;
        end
      end
      if (cval != 0) begin
        if (!taken && m_credit + cval <= 95) m_credit = m_credit + cval;
        else m_rej = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("credit_o",      credit_o,             8'(m_credit));
    chk("vend_o",        {7'd0, vend_o},       {7'd0, m_vending});
    chk("vend_sel_o",    {6'd0, vend_sel_o},   {6'd0, m_vend_sel});
    chk("pay_valid_o",   {7'd0, pay_valid_o},  {7'd0, m_paying});
    chk("pay_coin_o",    {6'd0, pay_coin_o},
        {6'd0, m_paying ? coin_code(greedy(m_credit)) : 2'b00});
    chk("busy_o",        {7'd0, busy_o},       {7'd0, (m_vending | m_paying)});
    chk("coin_reject_o", {7'd0, coin_reject_o}, {7'd0, m_rej});
    chk("sel_err_o",     {7'd0, sel_err_o},    {7'd0, m_serr});
  endtask

  // One clock: drive on the falling edge, check just after the rising edge
  task automatic cyc(input bit n, d, q, sv, input bit [1:0] s,
                     input bit c, a, r, rs);
    @(negedge clk);
    nickle_i = n; dime_i = d; quarter_i = q;
    sel_valid_i = sv; sel_i = s; cancel_i = c;
    vend_ack_i = a; pay_ready_i = r; rst_ni = rs;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();                  cyc(0,0,0,0,2'b00,0,0,0,1); endtask
  task automatic coin(input bit n, d, q); cyc(n,d,q,0,2'b00,0,0,0,1); endtask
  task automatic pick(input bit [1:0] s); cyc(0,0,0,1,s,0,0,0,1);     endtask
  task automatic ack();                   cyc(0,0,0,0,2'b00,0,1,0,1); endtask
  task automatic cancel();                cyc(0,0,0,0,2'b00,1,0,0,1); endtask
  task automatic take();                  cyc(0,0,0,0,2'b00,0,0,1,1); endtask

  // Accept coins until the model has nothing left to pay (bounded)
  task automatic drain();
    for (int i = 0; i < 20 && m_paying; i++) take();
  endtask

  initial begin
    rst_ni = 0; nickle_i = 0; dime_i = 0; quarter_i = 0;
    sel_valid_i = 0; sel_i = 0; cancel_i = 0; vend_ack_i = 0; pay_ready_i = 0;

    // Reset state
    cyc(0,0,0,0,2'b00,0,0,0,0);
    cyc(0,0,0,0,2'b00,0,0,0,0);

    // Quarter, buy A, nickel change
    coin(0,0,1);
    pick(2'b01);
    idle(); idle();
    ack();
    take();
    idle();

    // Insufficient credit, then a successful B with a dime back
    coin(0,1,0); coin(0,1,0);
    pick(2'b10);
    idle();
    coin(0,0,1);
    pick(2'b10);
    ack();
    take();

    // Refund of 40 with three stalled cycles per coin
    coin(0,0,1); coin(0,1,0); coin(1,0,0);
    cancel();
    for (int k = 0; k < 3; k++) begin
      idle(); idle(); idle();
      take();
    end
    idle();

    // Credit ceiling
    coin(0,0,1); coin(0,0,1); coin(0,0,1); coin(0,1,0); coin(1,0,0);
    coin(0,0,1);
    coin(1,0,0);
    coin(0,1,0);
    cancel();
    drain();
    coin(1,1,0);
    cancel();
    drain();

    // Events while busy are ignored or rejected
    coin(0,0,1); coin(0,0,1);
    pick(2'b01);
    coin(0,0,1);
    cancel();
    cyc(0,0,0,1,2'b11,0,0,0,1);
    ack();
    coin(0,1,0);
    cancel();
    cyc(0,0,0,1,2'b01,0,0,0,1);
    take();
    coin(1,0,0);
    drain();

    // Selection and coin in the same collect cycle
    coin(0,0,1);
    cyc(0,1,0,1,2'b01,0,0,0,1);
    ack();
    drain();

    // Reset in the middle of a payout
    coin(0,0,1); coin(1,0,0);
    cancel();
    idle();
    cyc(0,0,0,0,2'b00,0,0,0,0);
    idle();
    coin(0,0,1);
    cancel();
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0,7) == 0, $urandom_range(0,7) == 0,
          $urandom_range(0,7) == 0, $urandom_range(0,5) == 0,
          2'($urandom_range(0,3)), $urandom_range(0,19) == 0,
          $urandom_range(0,3) == 0, $urandom_range(0,1) == 0,
          $urandom_range(0,99) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vend_controller
`default_nettype wire
